opcode_decoder_6x64: RTL and testbench
======================================

Name: opcode_decoder_6x64

Overview:
- Registered 6-to-64 one-hot decoder for the single-cycle processor's control path.
- Converts a 6-bit opcode/funct field from instruction memory into a 64-bit one-hot select vector.
- The vector drives instruction-specific control lines (ADD, NOR, LW, SW, BEQ, ...).
- One clock domain; output registered once.

Parameters:
- none (widths fixed: 6 in, 64 out)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0  input  1  opcode bit 5 (MSB)
- in1  input  1  opcode bit 4
- in2  input  1  opcode bit 3
- in3  input  1  opcode bit 2
- in4  input  1  opcode bit 1
- in5  input  1  opcode bit 0 (LSB)
- out  output  64  one-hot decode; out[k] high when the opcode equals k

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Index formation: idx = {in0,in1,in2,in3,in4,in5}. in0 is the MSB; a field written as "100000" maps in0=1 and in1..in5=0, so idx = 32.
- Decode is combinational: next_out = 64'b1 << idx. Exactly one bit is set for every idx in 0..63; there are no invalid codes.
- Registration: next_out is captured into out on every rising edge of clk. No enable; out updates every cycle.
- Latency: 1 cycle. Inputs stable before edge N give out valid after edge N.
- Reset: rst_n low forces out = 64'h0 immediately, with no clock needed. This is the only state in which out is not one-hot.
- Reset deassertion: takes effect asynchronously. The first rising edge with rst_n high loads the decode of the current inputs.
- Reset mid-operation: out clears at once. Input changes while rst_n is low are ignored; out stays 0.
- Input X/Z: no special handling required. The bench only drives 0/1.
- No state machine, no handshake, no arithmetic beyond the index shift.

Decomposition:
- Shared package:
  - localparams OPC_W = 6 and DEC_W = 64.
  - Named opcode constants: OPC_BEQ = 6'b000100, OPC_ADD = 6'b100000, OPC_LW = 6'b100011, OPC_NOR = 6'b100111, OPC_SW = 6'b101011.
- Natural sub-module: decoder_3x8 (3-bit in, 8-bit one-hot out, combinational).
  - Two instances: high group {in0,in1,in2} and low group {in3,in4,in5}.
  - out[8*h+l] = hi[h] & lo[l], generated by a 64-way AND array.
  - The top level adds the 64-bit register with async clear.

Test Plan:
- Reset: rst_n=0 with any inputs -> out=64'h0 immediately, no clock edge. Release rst_n, drive 000000, one edge -> out=64'h0000_0000_0000_0001.
- Walking MSB-side inputs: 100000 -> 64'h0000_0001_0000_0000; 110000 -> 64'h0001_0000_0000_0000; 111000 -> 64'h0100_0000_0000_0000. Each is checked one edge after apply.
- LSB-side and mixed: 000100 -> 64'h0000_0000_0000_0010; 000010 -> 64'h4; 000001 -> 64'h2; 011111 -> 64'h0000_0000_8000_0000.
- Instruction codes:
  - ADD 100000 -> bit 32
  - NOR 100111 -> 64'h0000_0080_0000_0000 (bit 39)
  - LW 100011 -> 64'h0000_0008_0000_0000 (bit 35)
  - SW 101011 -> 64'h0000_0800_0000_0000 (bit 43)
  - BEQ 000100 -> bit 4
- Exhaustive plus latency:
  - Sweep idx 0..63 on consecutive edges; out == 1<<idx one cycle later, with popcount(out)==1 every cycle after reset.
  - Change inputs between edges; out does not change until the next rising edge.
- Mid-run reset: while out=bit 43, assert rst_n low between edges -> out=0 at once. Toggle inputs while in reset -> out stays 0. Deassert -> next edge shows decode of current inputs.

Source files
------------

// File: rtl/opcode_decoder_6x64_pkg.sv
// +----------------------------------------------------------------------------+
// | opcode_decoder_6x64_pkg : widths and named opcodes for the 6-to-64 decoder |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package opcode_decoder_6x64_pkg;

    localparam int OPC_W = 6;
    localparam int DEC_W = 64;

    localparam logic [OPC_W-1:0] OPC_BEQ = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] OPC_LW  = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_NOR = 6'b100111;
    localparam logic [OPC_W-1:0] OPC_SW  = 6'b101011;

endpackage : opcode_decoder_6x64_pkg

`default_nettype wire

// File: rtl/opcode_decoder_6x64_decoder_3x8.sv
// +----------------------------------------------------------------------------+
// | decoder_3x8 : combinational 3-to-8 one-hot decoder                         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module decoder_3x8 (
    input  logic [2:0] sel_i,
    output logic [7:0] dec_o
);

    assign dec_o = 8'b0000_0001 << sel_i;

endmodule : decoder_3x8

`default_nettype wire

// File: rtl/opcode_decoder_6x64.sv
// +----------------------------------------------------------------------------+
// | opcode_decoder_6x64 : registered 6-to-64 one-hot opcode decoder            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module opcode_decoder_6x64
    import opcode_decoder_6x64_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    input  logic             in4,
    input  logic             in5,
    output logic [DEC_W-1:0] out
);

    logic [7:0]       w_hi;
    logic [7:0]       w_lo;
    logic [DEC_W-1:0] out_d;
    logic [DEC_W-1:0] out_q;

    // in0 is the opcode MSB, so it leads the high group.
    decoder_3x8 u_dec_hi (
        .sel_i ({in0, in1, in2}),
        .dec_o (w_hi)
    );

    decoder_3x8 u_dec_lo (
        .sel_i ({in3, in4, in5}),
        .dec_o (w_lo)
    );

    for (genvar h = 0; h < 8; h++) begin : g_hi
        for (genvar l = 0; l < 8; l++) begin : g_lo
            assign out_d[8*h+l] = w_hi[h] & w_lo[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : opcode_decoder_6x64

`default_nettype wire

// File: tb/tb_opcode_decoder_6x64.sv
// +----------------------------------------------------------------------------+
// | tb_opcode_decoder_6x64 : self-checking bench for opcode_decoder_6x64       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_opcode_decoder_6x64;
    import opcode_decoder_6x64_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in0, in1, in2, in3, in4, in5;
    logic [63:0] out;

    int checks;
    int errors;

    opcode_decoder_6x64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .in5   (in5),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit k is set exactly when the opcode value equals k.
    function automatic logic [63:0] ref_decode(input logic [5:0] opc);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) r[k] = (k == int'(opc));
        return r;
    endfunction

    task automatic set_in(input logic [5:0] v);
        {in0, in1, in2, in3, in4, in5} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_onehot(input string tag);
        checks++;
        assert ($countones(out) == 1) else begin
            errors++;
            $error("FAIL %s: observed popcount %0d expected 1", tag, $countones(out));
        end
    endtask

    logic [5:0]  dir_opc [12];
    logic [63:0] dir_exp [12];
    logic [5:0]  a, b;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        set_in(6'b101010);

        dir_opc[0]  = 6'b100000; dir_exp[0]  = 64'h0000_0001_0000_0000;
        dir_opc[1]  = 6'b110000; dir_exp[1]  = 64'h0001_0000_0000_0000;
        dir_opc[2]  = 6'b111000; dir_exp[2]  = 64'h0100_0000_0000_0000;
        dir_opc[3]  = 6'b000100; dir_exp[3]  = 64'h0000_0000_0000_0010;
        dir_opc[4]  = 6'b000010; dir_exp[4]  = 64'h0000_0000_0000_0004;
        dir_opc[5]  = 6'b000001; dir_exp[5]  = 64'h0000_0000_0000_0002;
        dir_opc[6]  = 6'b011111; dir_exp[6]  = 64'h0000_0000_8000_0000;
        dir_opc[7]  = OPC_ADD;   dir_exp[7]  = 64'h0000_0001_0000_0000;
        dir_opc[8]  = OPC_NOR;   dir_exp[8]  = 64'h0000_0080_0000_0000;
        dir_opc[9]  = OPC_LW;    dir_exp[9]  = 64'h0000_0008_0000_0000;
        dir_opc[10] = OPC_SW;    dir_exp[10] = 64'h0000_0800_0000_0000;
        dir_opc[11] = OPC_BEQ;   dir_exp[11] = 64'h0000_0000_0000_0010;

        // Asynchronous reset before any clock edge (first posedge at t=5).
        #1 rst_n = 1'b0;
        #1 chk("reset_no_clock", out, 64'h0);
        step();
        set_in(6'b111111);
        step();
        chk("reset_holds_zero", out, 64'h0);

        set_in(6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_before_edge", out, 64'h0);
        step();
        chk("first_after_reset", out, 64'h0000_0000_0000_0001);

        // Directed patterns and instruction codes.
        for (int i = 0; i < 12; i++) begin
            set_in(dir_opc[i]);
            step();
            chk($sformatf("directed_%0d_const", i), out, dir_exp[i]);
            chk($sformatf("directed_%0d_model", i), out, ref_decode(dir_opc[i]));
        end

        // Exhaustive sweep on consecutive edges.
        for (int i = 0; i < 64; i++) begin
            set_in(6'(i));
            step();
            chk($sformatf("sweep_%0d", i), out, ref_decode(6'(i)));
            chk_onehot($sformatf("sweep_onehot_%0d", i));
        end

        // Random opcodes with mid-cycle input changes: output holds until the edge.
        for (int i = 0; i < 40; i++) begin
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            set_in(a);
            step();
            chk($sformatf("rand_%0d", i), out, ref_decode(a));
            set_in(b);
            #3;
            chk($sformatf("rand_hold_%0d", i), out, ref_decode(a));
            step();
            chk($sformatf("rand_next_%0d", i), out, ref_decode(b));
            chk_onehot($sformatf("rand_onehot_%0d", i));
        end

        // Mid-run reset while SW is decoded.
        set_in(OPC_SW);
        step();
        chk("midrun_sw", out, 64'h0000_0800_0000_0000);
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset_immediate", out, 64'h0);
        for (int i = 0; i < 4; i++) begin
            set_in(6'($urandom_range(0, 63)));
            step();
            chk($sformatf("midrun_in_reset_%0d", i), out, 64'h0);
        end
        a = 6'($urandom_range(0, 63));
        set_in(a);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrun_release_before_edge", out, 64'h0);
        step();
        chk("midrun_after_release", out, ref_decode(a));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_opcode_decoder_6x64

`default_nettype wire
